// File: rtl/mmio_arbiter_if.sv
// Request/response signals for both masters plus the shared bridge data port.
interface mmio_arbiter_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_byteen;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_byteen;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_rdata;
    logic [1:0]  bus_owner;

    modport slave (
        input  m0_req, m0_addr, m0_wdata, m0_byteen,
        input  m1_req, m1_addr, m1_wdata, m1_byteen,
        input  bus_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack,
        output bus_addr, bus_wdata, bus_byteen, bus_owner
    );

    modport master (
        output m0_req, m0_addr, m0_wdata, m0_byteen,
        output m1_req, m1_addr, m1_wdata, m1_byteen,
        output bus_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack,
        input  bus_addr, bus_wdata, bus_byteen, bus_owner
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: one transaction at a time, ack LATENCY+1 cycles after the IDLE sample; late requesters wait.
// ARB_FIXED_PRIO_EN selects master-0-wins ties instead of round-robin.
module mmio_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic           clk,
    input  logic           reset,
    mmio_arbiter_if.slave  mmio
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        last_grant;
    logic        owner_m1;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  byteen_q;
    logic [31:0] rdata0_q, rdata1_q;
    logic        grant_vld, grant_m1;
    logic        m0_ack, m1_ack;
    logic [3:0]  bus_byteen;
    logic [1:0]  bus_owner;

    always_comb begin
        grant_vld  = mmio.m0_req | mmio.m1_req;
`ifdef ARB_FIXED_PRIO_EN
        grant_m1   = mmio.m1_req & ~mmio.m0_req;
`else
        grant_m1   = mmio.m1_req & (~mmio.m0_req | ~last_grant);
`endif
        state_nxt  = state;
        cnt_nxt    = cnt;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        bus_byteen = 4'h0;
        bus_owner  = 2'b00;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                bus_owner = owner_m1 ? 2'b10 : 2'b01;
                // Only the first BUSY cycle carries byte enables so a write lands once.
                if (cnt == CNT_LOAD) bus_byteen = byteen_q;
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                bus_owner = owner_m1 ? 2'b10 : 2'b01;
                m0_ack    = ~owner_m1;
                m1_ack    = owner_m1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            owner_m1   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            byteen_q   <= 4'h0;
            rdata0_q   <= 32'h0;
            rdata1_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && grant_vld) begin
                last_grant <= grant_m1;
                owner_m1   <= grant_m1;
                addr_q     <= grant_m1 ? mmio.m1_addr   : mmio.m0_addr;
                wdata_q    <= grant_m1 ? mmio.m1_wdata  : mmio.m0_wdata;
                byteen_q   <= grant_m1 ? mmio.m1_byteen : mmio.m0_byteen;
            end
            if (state == BUSY && cnt == 4'd0) begin
                if (owner_m1) rdata1_q <= mmio.bus_rdata;
                else          rdata0_q <= mmio.bus_rdata;
            end
        end
    end

    assign mmio.m0_ack     = m0_ack;
    assign mmio.m1_ack     = m1_ack;
    assign mmio.m0_rdata   = rdata0_q;
    assign mmio.m1_rdata   = rdata1_q;
    assign mmio.bus_addr   = addr_q;
    assign mmio.bus_wdata  = wdata_q;
    assign mmio.bus_byteen = bus_byteen;
    assign mmio.bus_owner  = bus_owner;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench: three arbiter instances (LATENCY 1, 3, 4) sharing one clock, separate resets.
module tb_mmio_arbiter;
    logic clk = 1'b0;
    logic rst1 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mmio_arbiter_if if1();
    mmio_arbiter_if if3();
    mmio_arbiter_if if4();

    mmio_arbiter #(.LATENCY(1)) dut1 (.clk(clk), .reset(rst1), .mmio(if1));
    mmio_arbiter #(.LATENCY(3)) dut3 (.clk(clk), .reset(rst3), .mmio(if3));
    mmio_arbiter #(.LATENCY(4)) dut4 (.clk(clk), .reset(rst4), .mmio(if4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        if1.m0_req = 0; if1.m0_addr = 0; if1.m0_wdata = 0; if1.m0_byteen = 0;
        if1.m1_req = 0; if1.m1_addr = 0; if1.m1_wdata = 0; if1.m1_byteen = 0; if1.bus_rdata = 0;
        if3.m0_req = 0; if3.m0_addr = 0; if3.m0_wdata = 0; if3.m0_byteen = 0;
        if3.m1_req = 0; if3.m1_addr = 0; if3.m1_wdata = 0; if3.m1_byteen = 0; if3.bus_rdata = 0;
        if4.m0_req = 0; if4.m0_addr = 0; if4.m0_wdata = 0; if4.m0_byteen = 0;
        if4.m1_req = 0; if4.m1_addr = 0; if4.m1_wdata = 0; if4.m1_byteen = 0; if4.bus_rdata = 0;
    endtask

    task automatic test_reset();
        tests++; if (if1.bus_owner !== 2'b00) begin fails++; $display("FAIL rst_owner got %b exp 00", if1.bus_owner); end
        tests++; if ({if1.m0_ack, if1.m1_ack} !== 2'b00) begin fails++; $display("FAIL rst_ack got %b exp 00", {if1.m0_ack, if1.m1_ack}); end
        tests++; if ({if3.m0_rdata, if3.m1_rdata} !== 64'h0) begin fails++; $display("FAIL rst_rdata got %h exp 0", {if3.m0_rdata, if3.m1_rdata}); end
        tests++; if ({if4.bus_addr, if4.bus_wdata} !== 64'h0) begin fails++; $display("FAIL rst_bus got %h exp 0", {if4.bus_addr, if4.bus_wdata}); end
        tests++; if (if4.bus_byteen !== 4'h0) begin fails++; $display("FAIL rst_byteen got %h exp 0", if4.bus_byteen); end
    endtask

    // LATENCY=1 write from master 0: ack two cycles after the IDLE sample.
    task automatic test_write();
        if1.m0_addr = 32'h0000_0010; if1.m0_wdata = 32'hDEAD_BEEF; if1.m0_byteen = 4'hF; if1.m0_req = 1;
        tick();
        tests++; if (if1.bus_byteen !== 4'hF) begin fails++; $display("FAIL wr_byteen got %h exp f", if1.bus_byteen); end
        tests++; if (if1.bus_addr !== 32'h10) begin fails++; $display("FAIL wr_addr got %h exp 10", if1.bus_addr); end
        tests++; if (if1.bus_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_wdata got %h exp deadbeef", if1.bus_wdata); end
        tests++; if (if1.bus_owner !== 2'b01) begin fails++; $display("FAIL wr_owner_busy got %b exp 01", if1.bus_owner); end
        tests++; if (if1.m0_ack !== 1'b0) begin fails++; $display("FAIL wr_ack_early got %b exp 0", if1.m0_ack); end
        tick();
        tests++; if (if1.m0_ack !== 1'b1) begin fails++; $display("FAIL wr_ack got %b exp 1", if1.m0_ack); end
        tests++; if (if1.bus_byteen !== 4'h0) begin fails++; $display("FAIL wr_byteen_resp got %h exp 0", if1.bus_byteen); end
        tests++; if (if1.bus_owner !== 2'b01) begin fails++; $display("FAIL wr_owner_resp got %b exp 01", if1.bus_owner); end
        tick();
        if1.m0_req = 0;
        tests++; if ({if1.m0_ack, if1.bus_owner} !== 3'b000) begin fails++; $display("FAIL wr_idle got %b exp 000", {if1.m0_ack, if1.bus_owner}); end
        tests++; if (if1.bus_addr !== 32'h10) begin fails++; $display("FAIL wr_addr_hold got %h exp 10", if1.bus_addr); end
        tick();
    endtask

    // LATENCY=3 read from master 1; data is taken only in the last BUSY cycle.
    task automatic test_read();
        if3.m1_addr = 32'h0000_7f04; if3.m1_wdata = 32'h0; if3.m1_byteen = 4'h0; if3.m1_req = 1;
        if3.bus_rdata = 32'hBAD0_BAD0;
        tick();
        tests++; if (if3.bus_owner !== 2'b10) begin fails++; $display("FAIL rd_owner got %b exp 10", if3.bus_owner); end
        tests++; if (if3.bus_byteen !== 4'h0) begin fails++; $display("FAIL rd_byteen1 got %h exp 0", if3.bus_byteen); end
        tests++; if (if3.bus_addr !== 32'h7f04) begin fails++; $display("FAIL rd_addr got %h exp 7f04", if3.bus_addr); end
        tick();
        tick();
        if3.bus_rdata = 32'h1234_5678;
        tests++; if (if3.m1_ack !== 1'b0) begin fails++; $display("FAIL rd_ack_early got %b exp 0", if3.m1_ack); end
        tests++; if (if3.bus_byteen !== 4'h0) begin fails++; $display("FAIL rd_byteen3 got %h exp 0", if3.bus_byteen); end
        tick();
        if3.bus_rdata = 32'h0;
        tests++; if (if3.m1_ack !== 1'b1) begin fails++; $display("FAIL rd_ack got %b exp 1", if3.m1_ack); end
        tests++; if (if3.m1_rdata !== 32'h12345678) begin fails++; $display("FAIL rd_data got %h exp 12345678", if3.m1_rdata); end
        tests++; if ({if3.m0_ack, if3.m0_rdata} !== 33'h0) begin fails++; $display("FAIL rd_loser got %h exp 0", {if3.m0_ack, if3.m0_rdata}); end
        tick();
        if3.m1_req = 0;
        tests++; if (if3.m1_rdata !== 32'h12345678) begin fails++; $display("FAIL rd_data_hold got %h exp 12345678", if3.m1_rdata); end
        tick();
    endtask

    // Both masters held high from reset: round-robin alternates, fixed priority keeps master 0.
    task automatic test_tie();
        logic [1:0] exp;
        logic       got_ack;
        rst1 = 1;
        tick();
        rst1 = 0;
        if1.m0_addr = 32'hA0; if1.m0_byteen = 4'h0; if1.m0_req = 1;
        if1.m1_addr = 32'hB0; if1.m1_byteen = 4'h0; if1.m1_req = 1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            exp = 2'b01;
`else
            exp = (k % 2 == 1) ? 2'b10 : 2'b01;
`endif
            tick();
            tests++; if (if1.bus_owner !== exp) begin fails++; $display("FAIL tie_owner%0d got %b exp %b", k, if1.bus_owner, exp); end
            tests++; if (if1.bus_addr !== ((exp == 2'b01) ? 32'hA0 : 32'hB0)) begin fails++; $display("FAIL tie_addr%0d got %h", k, if1.bus_addr); end
            tick();
            got_ack = (exp == 2'b01) ? if1.m0_ack : if1.m1_ack;
            tests++; if (got_ack !== 1'b1) begin fails++; $display("FAIL tie_ack%0d got %b exp 1", k, got_ack); end
            tick();
            tests++; if (if1.bus_owner !== 2'b00) begin fails++; $display("FAIL tie_idle%0d got %b exp 00", k, if1.bus_owner); end
        end
        if1.m0_req = 0; if1.m1_req = 0;
        tick();
    endtask

    // Master 1 arrives while master 0's partial write is in flight and is served right after.
    task automatic test_back_to_back();
        if3.m0_addr = 32'h0000_7f20; if3.m0_wdata = 32'hA5A5_A5A5; if3.m0_byteen = 4'b0011; if3.m0_req = 1;
        tick();
        if3.m1_addr = 32'h100; if3.m1_wdata = 32'hCAFE_F00D; if3.m1_byteen = 4'b1100; if3.m1_req = 1;
        if3.bus_rdata = 32'h55AA_55AA;
        tests++; if (if3.bus_byteen !== 4'b0011) begin fails++; $display("FAIL b2b_byteen1 got %b exp 0011", if3.bus_byteen); end
        tick();
        tests++; if (if3.bus_byteen !== 4'h0) begin fails++; $display("FAIL b2b_byteen2 got %b exp 0000", if3.bus_byteen); end
        tests++; if (if3.bus_addr !== 32'h7f20) begin fails++; $display("FAIL b2b_addr2 got %h exp 7f20", if3.bus_addr); end
        tick();
        tests++; if ({if3.bus_owner, if3.bus_addr} !== {2'b01, 32'h7f20}) begin fails++; $display("FAIL b2b_busy3 got %h", {if3.bus_owner, if3.bus_addr}); end
        tick();
        tests++; if ({if3.m0_ack, if3.m1_ack} !== 2'b10) begin fails++; $display("FAIL b2b_ack0 got %b exp 10", {if3.m0_ack, if3.m1_ack}); end
        tick();
        if3.m0_req = 0;
        tests++; if (if3.bus_owner !== 2'b00) begin fails++; $display("FAIL b2b_idle got %b exp 00", if3.bus_owner); end
        tick();
        tests++; if (if3.bus_owner !== 2'b10) begin fails++; $display("FAIL b2b_owner1 got %b exp 10", if3.bus_owner); end
        tests++; if ({if3.bus_addr, if3.bus_wdata} !== {32'h100, 32'hCAFEF00D}) begin fails++; $display("FAIL b2b_payload1 got %h", {if3.bus_addr, if3.bus_wdata}); end
        tests++; if (if3.bus_byteen !== 4'b1100) begin fails++; $display("FAIL b2b_byteen_m1 got %b exp 1100", if3.bus_byteen); end
        tick();
        tick();
        tick();
        tests++; if ({if3.m0_ack, if3.m1_ack} !== 2'b01) begin fails++; $display("FAIL b2b_ack1 got %b exp 01", {if3.m0_ack, if3.m1_ack}); end
        tests++; if ({if3.m0_rdata, if3.m1_rdata} !== {32'h55AA55AA, 32'h55AA55AA}) begin fails++; $display("FAIL b2b_rdata got %h", {if3.m0_rdata, if3.m1_rdata}); end
        tick();
        if3.m1_req = 0;
        tick();
    endtask

    // LATENCY=4 write aborted by reset in its second BUSY cycle.
    task automatic test_reset_mid();
        int be_cnt;
        int ack_cnt;
        be_cnt = 0;
        ack_cnt = 0;
        if4.m0_addr = 32'h40; if4.m0_wdata = 32'h1111_2222; if4.m0_byteen = 4'hF; if4.m0_req = 1;
        tick();
        if (if4.bus_byteen != 4'h0) be_cnt++;
        tick();
        if (if4.bus_byteen != 4'h0) be_cnt++;
        rst4 = 1;
        tick();
        rst4 = 0;
        if4.m0_req = 0;
        tests++; if (if4.bus_owner !== 2'b00) begin fails++; $display("FAIL rstmid_owner got %b exp 00", if4.bus_owner); end
        tests++; if (if4.bus_byteen !== 4'h0) begin fails++; $display("FAIL rstmid_byteen got %h exp 0", if4.bus_byteen); end
        tests++; if (if4.bus_addr !== 32'h0) begin fails++; $display("FAIL rstmid_addr got %h exp 0", if4.bus_addr); end
        for (int i = 0; i < 6; i++) begin
            if (if4.m0_ack) ack_cnt++;
            if (if4.bus_byteen != 4'h0) be_cnt++;
            tick();
        end
        tests++; if (ack_cnt !== 0) begin fails++; $display("FAIL rstmid_ack got %0d exp 0", ack_cnt); end
        tests++; if (be_cnt !== 1) begin fails++; $display("FAIL rstmid_write_once got %0d exp 1", be_cnt); end
    endtask

    initial begin
        init_inputs();
        tick();
        tick();
        rst1 = 0; rst3 = 0; rst4 = 0;
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
